// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that grants one requester at a time ownership of a UART
// transmitter, framing ownership by req_last and revoking it with an idle watchdog.
module uart_tx_arb #(
  parameter int N            = 4,
  parameter int CONFIG_WIDTH = 32,
  parameter int TIMEOUT      = 1024
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [N*8-1:0]            req_data,
  input  logic [N-1:0]              req_valid,
  input  logic [N-1:0]              req_last,
  output logic [N-1:0]              req_ready,
  input  logic [N*CONFIG_WIDTH-1:0] req_conf,
  output logic [7:0]                tx_din,
  output logic                      tx_din_valid,
  input  logic                      tx_din_ready,
  output logic [CONFIG_WIDTH-1:0]   tx_conf,
  output logic [N-1:0]              grant,
  output logic                      busy,
  output logic                      timeout
);

  localparam int          PTR_W      = (N > 1) ? $clog2(N) : 1;
  localparam logic [15:0] IDLE_LIMIT = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN, WAIT} state_e;

  state_e                  state_q;
  logic [PTR_W-1:0]        ptr_q;
  logic [N-1:0]            grant_q;
  logic [CONFIG_WIDTH-1:0] conf_q;
  logic [15:0]             idle_q;
  logic                    timeout_q;

  logic [7:0]              data_a [N];
  logic [CONFIG_WIDTH-1:0] conf_a [N];
  logic [PTR_W-1:0]        sel_d;
  logic [PTR_W-1:0]        cand;
  logic                    sel_found;
  logic                    g_valid;
  logic                    g_last;
  logic                    accept;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign data_a[i] = req_data[8*i +: 8];
    assign conf_a[i] = req_conf[CONFIG_WIDTH*i +: CONFIG_WIDTH];
  end

  // Walk from the farthest candidate down so the nearest one after ptr wins.
  always_comb begin
    sel_found = 1'b0;
    sel_d     = ptr_q;
    cand      = ptr_q;
    for (int k = N; k >= 1; k--) begin
      cand = PTR_W'((int'(ptr_q) + k) % N);
      if (req_valid[cand]) begin
        sel_found = 1'b1;
        sel_d     = cand;
      end
    end
  end

  assign g_valid = req_valid[ptr_q];
  assign g_last  = req_last[ptr_q];
  assign accept  = (state_q == GRANT) && g_valid && tx_din_ready;

  always_comb begin
    tx_din       = '0;
    tx_din_valid = 1'b0;
    req_ready    = '0;
    if (state_q == GRANT) begin
      tx_din           = data_a[ptr_q];
      tx_din_valid     = g_valid;
      req_ready[ptr_q] = accept;
    end
  end

  // An accept always clears the watchdog, so a final byte landing on the
  // limit cycle ends the packet normally instead of raising timeout.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= PTR_W'(N - 1);
      grant_q   <= '0;
      conf_q    <= '0;
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sel_found) begin
            state_q <= GRANT;
            ptr_q   <= sel_d;
            grant_q <= N'(1) << sel_d;
            conf_q  <= conf_a[sel_d];
            idle_q  <= '0;
          end
        end
        GRANT: begin
          if (accept) begin
            idle_q <= '0;
            if (g_last) begin
              state_q <= DRAIN;
            end
          end else if (idle_q == IDLE_LIMIT) begin
            state_q   <= DRAIN;
            timeout_q <= 1'b1;
          end else if (!g_valid) begin
            idle_q <= idle_q + 16'd1;
          end
        end
        DRAIN: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (tx_din_ready) begin
            state_q <= IDLE;
            grant_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx_conf = conf_q;
  assign grant   = grant_q;
  assign busy    = (state_q != IDLE);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: reset, arbitration order, packet framing,
// transmitter back-pressure, watchdog and asynchronous reset behaviour.
module tb_uart_tx_arb;

  localparam logic [31:0] CONF0 = 32'h0010_0000;
  localparam logic [31:0] CONF1 = 32'h0020_0001;
  localparam logic [31:0] CONF2 = 32'h0030_0000;
  localparam logic [31:0] CONF3 = 32'h0040_0001;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [31:0]  req_data;
  logic [3:0]   req_valid;
  logic [3:0]   req_last;
  logic [3:0]   req_ready;
  logic [127:0] req_conf;
  logic [7:0]   tx_din;
  logic         tx_din_valid;
  logic         tx_din_ready;
  logic [31:0]  tx_conf;
  logic [3:0]   grant;
  logic         busy;
  logic         timeout;

  logic [7:0]   dataA [4];
  int           checks = 0;
  int           errors = 0;

  assign req_data = {dataA[3], dataA[2], dataA[1], dataA[0]};
  assign req_conf = {CONF3, CONF2, CONF1, CONF0};

  always #5 clock = ~clock;

  uart_tx_arb #(.N(4), .CONFIG_WIDTH(32), .TIMEOUT(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_data(req_data), .req_valid(req_valid), .req_last(req_last), .req_ready(req_ready),
    .req_conf(req_conf),
    .tx_din(tx_din), .tx_din_valid(tx_din_valid), .tx_din_ready(tx_din_ready),
    .tx_conf(tx_conf), .grant(grant), .busy(busy), .timeout(timeout)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    req_valid    = '0;
    req_last     = '0;
    tx_din_ready = 1'b0;
    for (int i = 0; i < 4; i++) dataA[i[1:0]] = 8'h00;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    req_valid    = 4'b1111;
    req_last     = 4'b1111;
    tx_din_ready = 1'b1;
    for (int i = 0; i < 4; i++) dataA[i[1:0]] = 8'hFF;
    repeat (2) step();
    sample();
    checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL reset_grant: got %b want 0000", grant); end
    checks++; if ({busy, timeout, tx_din_valid} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b want 000", {busy, timeout, tx_din_valid}); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ready: got %b want 0000", req_ready); end
    checks++; if (tx_conf !== 32'h0) begin errors++; $display("[TB] FAIL reset_conf: got %h want 0", tx_conf); end
    checks++; if (tx_din !== 8'h00) begin errors++; $display("[TB] FAIL reset_din: got %h want 00", tx_din); end
    step();
    clear_inputs();
    reset_n = 1'b1;
  endtask

  task automatic test_first_grant();
    req_valid = 4'b0101;
    dataA[0]  = 8'h11;
    dataA[2]  = 8'h22;
    sample();
    checks++; if ({grant, tx_din_valid} !== 5'b0000_0) begin errors++; $display("[TB] FAIL first_idle: got %b want 00000", {grant, tx_din_valid}); end
    step(); sample();
    checks++; if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL first_grant: got %b want 0001", grant); end
    checks++; if (tx_conf !== CONF0) begin errors++; $display("[TB] FAIL first_conf: got %h want %h", tx_conf, CONF0); end
    checks++; if ({busy, tx_din_valid, tx_din, req_ready} !== {1'b1, 1'b1, 8'h11, 4'b0000}) begin errors++; $display("[TB] FAIL first_data: got %b/%b/%h/%b want 1/1/11/0000", busy, tx_din_valid, tx_din, req_ready); end
    step();
    tx_din_ready = 1'b1;
    req_last     = 4'b0001;
    sample();
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL first_accept: got %b want 0001", req_ready); end
    step();
    req_valid    = 4'b0100;
    req_last     = 4'b0000;
    tx_din_ready = 1'b0;
    sample();
    checks++; if ({busy, tx_din_valid, grant, req_ready} !== {1'b1, 1'b0, 4'b0001, 4'b0000}) begin errors++; $display("[TB] FAIL first_drain: got %b/%b/%b/%b want 1/0/0001/0000", busy, tx_din_valid, grant, req_ready); end
    step(); step();
    tx_din_ready = 1'b1;
    sample();
    checks++; if ({busy, grant} !== {1'b1, 4'b0001}) begin errors++; $display("[TB] FAIL first_wait: got %b/%b want 1/0001", busy, grant); end
    step(); sample();
    checks++; if ({busy, grant, tx_conf} !== {1'b0, 4'b0000, CONF0}) begin errors++; $display("[TB] FAIL first_release: got %b/%b/%h want 0/0000/%h", busy, grant, tx_conf, CONF0); end
    step(); sample();
    checks++; if ({grant, tx_conf, tx_din} !== {4'b0100, CONF2, 8'h22}) begin errors++; $display("[TB] FAIL first_next: got %b/%h/%h want 0100/%h/22", grant, tx_conf, tx_din, CONF2); end
  endtask

  task automatic test_back_to_back();
    int         sent [4] = '{0, 0, 0, 0};
    int         pkts [4] = '{2, 1, 1, 1};
    logic [3:0] gOrder [8];
    logic [3:0] expOrder [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] prevG = 4'b0000;
    logic [3:0] acc;
    int         nG = 0;
    int         total = 0;
    int         cyc = 0;
    bit         done = 1'b0;
    apply_reset();
    tx_din_ready = 1'b1;
    while (!done) begin
      for (int i = 0; i < 4; i++) begin
        req_valid[i[1:0]] = (sent[i[1:0]] < 2 * pkts[i[1:0]]);
        dataA[i[1:0]]     = {i[3:0], 4'(sent[i[1:0]])};
        req_last[i[1:0]]  = sent[i[1:0]][0];
      end
      sample();
      if (grant !== 4'b0000 && prevG === 4'b0000) begin
        if (nG < 8) gOrder[nG] = grant;
        nG++;
      end
      prevG = grant;
      checks++; if ($countones(req_ready) > 1) begin errors++; $display("[TB] FAIL b2b_onehot_ready: got %b want at most one bit", req_ready); end
      acc = req_ready;
      for (int i = 0; i < 4; i++) begin
        if (acc[i[1:0]]) begin
          checks++;
          if ({grant[i[1:0]], tx_din} !== {1'b1, dataA[i[1:0]]}) begin errors++; $display("[TB] FAIL b2b_byte: req %0d got grant=%b din=%h want din=%h", i, grant, tx_din, dataA[i[1:0]]); end
        end
      end
      step();
      for (int i = 0; i < 4; i++) begin
        if (acc[i[1:0]]) begin sent[i[1:0]]++; total++; end
      end
      cyc++;
      if (total == 10) done = 1'b1;
      else if (cyc > 200) begin
        checks++; errors++; done = 1'b1;
        $display("[TB] FAIL b2b_budget: got %0d bytes want 10 within 200 cycles", total);
      end
    end
    checks++; if (nG != 5) begin errors++; $display("[TB] FAIL b2b_grant_count: got %0d want 5", nG); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (gOrder[k] !== expOrder[k]) begin errors++; $display("[TB] FAIL b2b_order: grant %0d got %b want %b", k, gOrder[k], expOrder[k]); end
    end
  endtask

  task automatic test_long_hold();
    int sent1 = 0;
    int hold = 0;
    int c = 0;
    int lastAcc = -1;
    int g3At = -1;
    bit prevAcc = 1'b0;
    apply_reset();
    while (g3At < 0 && c < 100) begin
      if (prevAcc) hold = 11;
      else if (hold > 0) hold--;
      tx_din_ready = (hold == 0);
      req_valid    = {1'b1, 1'b0, (sent1 < 3), 1'b0};
      req_last     = {2'b00, (sent1 == 2), 1'b0};
      dataA[1]     = 8'(8'hA1 + sent1);
      dataA[3]     = 8'hB1;
      sample();
      prevAcc = req_ready[1];
      if (req_ready[1]) begin
        checks++; if (tx_din !== dataA[1]) begin errors++; $display("[TB] FAIL hold_byte: got %h want %h", tx_din, dataA[1]); end
        if (sent1 == 2) lastAcc = c;
      end
      if (lastAcc >= 0 && c > lastAcc && grant !== 4'b1000) begin
        checks++; if (tx_conf !== CONF1) begin errors++; $display("[TB] FAIL hold_conf: cycle %0d got %h want %h", c, tx_conf, CONF1); end
      end
      if (lastAcc >= 0 && c == lastAcc + 11) begin
        checks++; if ({busy, grant} !== {1'b1, 4'b0010}) begin errors++; $display("[TB] FAIL hold_wait: got %b/%b want 1/0010", busy, grant); end
      end
      if (grant === 4'b1000) g3At = c;
      step();
      if (prevAcc) sent1++;
      c++;
    end
    checks++; if (g3At - lastAcc != 14 || lastAcc < 0) begin errors++; $display("[TB] FAIL hold_latency: got last=%0d grant3=%0d want gap 14", lastAcc, g3At); end
    checks++; if (tx_conf !== CONF3) begin errors++; $display("[TB] FAIL hold_next_conf: got %h want %h", tx_conf, CONF3); end
  endtask

  task automatic test_timeout();
    apply_reset();
    for (int c = 0; c < 22; c++) begin
      req_valid    = {1'b1, (c <= 1), 2'b00};
      req_last     = 4'b0000;
      dataA[2]     = 8'h5A;
      dataA[3]     = 8'h6B;
      tx_din_ready = 1'b1;
      sample();
      if (c == 1) begin
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL to_accept: got %b want 0100", req_ready); end
      end else if (c >= 2 && c <= 17) begin
        checks++; if ({timeout, grant, req_ready} !== {1'b0, 4'b0100, 4'b0000}) begin errors++; $display("[TB] FAIL to_idle: cycle %0d got %b/%b/%b want 0/0100/0000", c, timeout, grant, req_ready); end
      end else if (c == 18) begin
        checks++; if ({timeout, busy, grant} !== {1'b1, 1'b1, 4'b0100}) begin errors++; $display("[TB] FAIL to_pulse: got %b/%b/%b want 1/1/0100", timeout, busy, grant); end
      end else if (c == 19) begin
        checks++; if ({timeout, busy, grant} !== {1'b0, 1'b1, 4'b0100}) begin errors++; $display("[TB] FAIL to_wait: got %b/%b/%b want 0/1/0100", timeout, busy, grant); end
      end else if (c == 20) begin
        checks++; if ({busy, grant} !== {1'b0, 4'b0000}) begin errors++; $display("[TB] FAIL to_release: got %b/%b want 0/0000", busy, grant); end
      end else if (c == 21) begin
        checks++; if ({grant, tx_conf, tx_din} !== {4'b1000, CONF3, 8'h6B}) begin errors++; $display("[TB] FAIL to_next: got %b/%h/%h want 1000/%h/6B", grant, tx_conf, tx_din, CONF3); end
      end
      step();
    end
  endtask

  task automatic test_timeout_race();
    apply_reset();
    for (int c = 0; c < 21; c++) begin
      req_valid    = {3'b000, (c <= 1 || c == 17)};
      req_last     = {2'b00, 1'b1, (c >= 2)};
      dataA[0]     = (c == 17) ? 8'hEE : 8'h10;
      tx_din_ready = 1'b1;
      sample();
      if (c == 1) begin
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL race_first: got %b want 0001", req_ready); end
      end else if (c == 16) begin
        checks++; if ({busy, grant, timeout, tx_din_valid} !== {1'b1, 4'b0001, 1'b0, 1'b0}) begin errors++; $display("[TB] FAIL race_ignore_last: got %b/%b/%b/%b want 1/0001/0/0", busy, grant, timeout, tx_din_valid); end
      end else if (c == 17) begin
        checks++; if ({req_ready, tx_din} !== {4'b0001, 8'hEE}) begin errors++; $display("[TB] FAIL race_accept: got %b/%h want 0001/EE", req_ready, tx_din); end
      end else if (c == 18) begin
        checks++; if ({timeout, busy, grant, tx_din_valid} !== {1'b0, 1'b1, 4'b0001, 1'b0}) begin errors++; $display("[TB] FAIL race_drain: got %b/%b/%b/%b want 0/1/0001/0", timeout, busy, grant, tx_din_valid); end
      end else if (c == 19) begin
        checks++; if ({timeout, busy} !== 2'b01) begin errors++; $display("[TB] FAIL race_wait: got %b/%b want 0/1", timeout, busy); end
      end else if (c == 20) begin
        checks++; if ({busy, grant} !== {1'b0, 4'b0000}) begin errors++; $display("[TB] FAIL race_idle: got %b/%b want 0/0000", busy, grant); end
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    req_valid    = 4'b0010;
    dataA[1]     = 8'h77;
    tx_din_ready = 1'b1;
    step(); sample();
    checks++; if ({grant, tx_conf} !== {4'b0010, CONF1}) begin errors++; $display("[TB] FAIL ar_pre: got %b/%h want 0010/%h", grant, tx_conf, CONF1); end
    step();
    req_valid = 4'b0111;
    dataA[0]  = 8'h01;
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if ({grant, busy, timeout, tx_din_valid, req_ready, tx_din} !== 19'h0) begin errors++; $display("[TB] FAIL ar_outputs: got %b/%b/%b/%b/%b/%h want all zero", grant, busy, timeout, tx_din_valid, req_ready, tx_din); end
    checks++; if (tx_conf !== 32'h0) begin errors++; $display("[TB] FAIL ar_conf: got %h want 0", tx_conf); end
    step();
    reset_n = 1'b1;
    sample();
    checks++; if ({busy, grant} !== {1'b0, 4'b0000}) begin errors++; $display("[TB] FAIL ar_idle: got %b/%b want 0/0000", busy, grant); end
    step(); sample();
    checks++; if ({grant, tx_conf, tx_din} !== {4'b0001, CONF0, 8'h01}) begin errors++; $display("[TB] FAIL ar_first_arb: got %b/%h/%h want 0001/%h/01", grant, tx_conf, tx_din, CONF0); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_first_grant();
    test_back_to_back();
    test_long_hold();
    test_timeout();
    test_timeout_race();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no completion want finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
